// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one word-wide memory port between the I-cache refill side and the data side.
// Latency: a request in IDLE raises mem_req next cycle; x_ready is combinational with mem_ready or watchdog abort.
// Backpressure: clients hold req until their ready pulse; one access outstanding, IDLE bubble between grants.
module memory_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_ready,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready,
  output logic                    timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_d_q, last_d_d;      // 1 = D side held the most recent grant
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          timeout_err_q, timeout_err_d;

  logic          pick_d;
  logic          wd_expired;
  logic          gnt_i, gnt_d;

  // D wins when it is the only requester, in fixed mode, or when I had the last turn
  assign pick_d     = d_req && (!i_req || (PRIORITY_MODE == 1) || !last_d_q);
  assign wd_expired = (wd_cnt_q == CW'(TIMEOUT_CYCLES));
  assign gnt_i      = (state_q == GRANT_I);
  assign gnt_d      = (state_q == GRANT_D);

  // Next-state: arbitrate in IDLE, leave a grant on completion or watchdog abort
  always_comb begin
    state_d       = state_q;
    last_d_d      = last_d_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d  = pick_d ? GRANT_D : GRANT_I;
          last_d_d = pick_d;
          wd_cnt_d = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        // Request lines are ignored here: a grant always runs to completion or abort
        if (mem_ready) begin
          state_d = IDLE;
        end else if (wd_expired) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset leaves last grant on D so I wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_d_q      <= 1'b1;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_d_q      <= last_d_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Memory-side mux from the granted client; bus is quiet in IDLE
  always_comb begin
    mem_req   = gnt_i | gnt_d;
    mem_we    = gnt_d & d_we;
    mem_addr  = gnt_i ? i_addr : (gnt_d ? d_addr : '0);
    mem_wdata = gnt_d ? d_wdata : '0;
    mem_wstrb = gnt_d ? d_wstrb : '0;
  end

  // Client completions: data only on a real mem_ready, an abort returns zero data
  always_comb begin
    i_ready = gnt_i & (mem_ready | wd_expired);
    d_ready = gnt_d & (mem_ready | wd_expired);
    i_rdata = (gnt_i && mem_ready) ? mem_rdata : '0;
    d_rdata = (gnt_d && mem_ready) ? mem_rdata : '0;
  end

  assign timeout_err = timeout_err_q;

endmodule
